// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle for uart_tx_arbiter.
// Requester i drives req_valid[i] and req_data[i*DATA_W +: DATA_W].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin UART transmit arbiter: grants one requester at a time, then
// serialises its byte as start / DATA_W data bits LSB first / STOP_BITS stop
// bits. Every bit boundary lands on a baud_tick edge.
module uart_tx_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int STOP_BITS = 1,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  uart_tx_arbiter_if.slave     req,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 frame_done
);

  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_d;
  logic [BW-1:0]     bit_idx;
  logic [1:0]        stop_cnt;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic              accept;
  logic              tx_d;
  logic              frame_done_d;
  logic [IDW:0]      cand;

  // Round-robin search: first valid id after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!win_found && req.req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && win_found;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; every non-IDLE transition is paced by baud_tick.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = SYNC;
      SYNC:  if (baud_tick) state_d = START;
      START: if (baud_tick) state_d = DATA;
      DATA:  if (baud_tick && bit_idx == BW'(DATA_W-1)) state_d = STOP;
      STOP:  if (baud_tick && stop_cnt == 2'(STOP_BITS-1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake, busy, and next values of the registered line/pulse.
  // tx is decoded from the next state so it changes on the same edge as it.
  always_comb begin
    req.req_ready = '0;
    if (accept) begin
      req.req_ready[win_id] = 1'b1;
    end
    busy = (state != IDLE);

    shreg_d = shreg;
    if (accept) begin
      shreg_d = req.req_data[win_id*DATA_W +: DATA_W];
    end else if (state == DATA && baud_tick) begin
      shreg_d = shreg >> 1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase

    frame_done_d = (state == STOP) && baud_tick && (stop_cnt == 2'(STOP_BITS-1));
  end

  // Datapath registers: shifter, bit/stop counters, grant bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx         <= 1'b1;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= '0;
      grant_id   <= '0;
      rr_ptr     <= IDW'(NUM_REQ-1);
    end else begin
      tx         <= tx_d;
      frame_done <= frame_done_d;
      shreg      <= shreg_d;
      if (accept) begin
        grant_id <= win_id;
        rr_ptr   <= win_id;
      end
      if (state == START && baud_tick) begin
        bit_idx  <= '0;
        stop_cnt <= '0;
      end else if (state == DATA && baud_tick) begin
        bit_idx  <= bit_idx + 1'b1;
      end else if (state == STOP && baud_tick) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: baud tick every 4 clocks, one 1-stop
// instance (a) and one 2-stop instance (b).
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [1:0] tick_cnt = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt  <= tick_cnt + 2'd1;
    baud_tick <= (tick_cnt == 2'd3);
  end

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus_b ();

  logic       tx_a, busy_a, fd_a;
  logic       tx_b, busy_b, fd_b;
  logic [1:0] gid_a, gid_b;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(bus_a),
    .tx(tx_a), .busy(busy_a), .grant_id(gid_a), .frame_done(fd_a)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(bus_b),
    .tx(tx_b), .busy(busy_b), .grant_id(gid_b), .frame_done(fd_b)
  );

  int fd_cnt_a = 0;
  int rdy2_cnt = 0;
  always @(negedge clk) begin
    if (fd_a === 1'b1) fd_cnt_a++;
    if (bus_a.req_ready[2] === 1'b1) rdy2_cnt++;
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; waits for the start bit, then samples every clock of
  // the frame. bad counts samples inconsistent with a 4-clock bit, a wrong
  // start/stop level, or an early frame_done.
  task automatic rx_frame(input bit sel_b, input int stop_bits,
                          output logic [7:0] b, output int bad, output int lows);
    int n;
    int k;
    logic s;
    b = '0; bad = 0; lows = 0;
    n = (1 + 8 + stop_bits) * 4;
    k = 0;
    while (k < 40 && (sel_b ? tx_b : tx_a) !== 1'b0) begin
      @(negedge clk);
      k++;
    end
    if ((sel_b ? tx_b : tx_a) !== 1'b0) begin
      bad = 999;
      return;
    end
    for (int i = 0; i < n; i++) begin
      s = sel_b ? tx_b : tx_a;
      if (s === 1'b0) lows++;
      if (i < 4) begin
        if (s !== 1'b0) bad++;
      end else if (i < 36) begin
        if (i % 4 == 0) b[3'((i-4)/4)] = s;
        else if (s !== b[3'((i-4)/4)]) bad++;
      end else begin
        if (s !== 1'b1) bad++;
      end
      if ((sel_b ? fd_b : fd_a) !== 1'b0) bad++;
      @(negedge clk);
    end
  endtask

  // At an idle negedge with requester id expected to win on instance a.
  task automatic grant_and_rx(input int id, input int exp_byte);
    logic [7:0] b;
    int bad, lows;
    check("ready_onehot", 32'(bus_a.req_ready), 1 << id);
    @(negedge clk);
    check("ready_pulse_1clk", 32'(bus_a.req_ready), 0);
    bus_a.req_valid[id] = 1'b0;
    check("grant_id", 32'(gid_a), id);
    check("busy_high", 32'(busy_a), 1);
    rx_frame(1'b0, 1, b, bad, lows);
    check("rx_byte", 32'(b), exp_byte);
    check("rx_bit_timing", bad, 0);
    check("frame_done", 32'(fd_a), 1);
    check("busy_low", 32'(busy_a), 0);
  endtask

  initial begin
    logic [7:0] b;
    int bad, lows, snap;

    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 1);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ready", 32'(bus_a.req_ready), 0);
    check("rst_grant_id", 32'(gid_a), 0);
    check("rst_frame_done", 32'(fd_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte 0xA5 from requester 0
    bus_a.req_data[7:0] = 8'hA5;
    bus_a.req_valid[0]  = 1'b1;
    #1;
    check("t1_ready", 32'(bus_a.req_ready), 1);
    @(negedge clk);
    check("t1_ready_pulse", 32'(bus_a.req_ready), 0);
    bus_a.req_valid[0] = 1'b0;
    check("t1_busy", 32'(busy_a), 1);
    rx_frame(1'b0, 1, b, bad, lows);
    check("t1_byte", 32'(b), 32'h A5);
    check("t1_timing", bad, 0);
    check("t1_low_clks", lows, 20);
    check("t1_frame_done", 32'(fd_a), 1);
    check("t1_busy_fall", 32'(busy_a), 0);
    check("t1_grant_id", 32'(gid_a), 0);
    @(negedge clk);
    check("t1_fd_one_clk", 32'(fd_a), 0);

    // 2: all four requesters at once, grant order 0..3 after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_a.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus_a.req_valid = 4'b1111;
    #1;
    snap = fd_cnt_a;
    grant_and_rx(0, 32'h11);
    grant_and_rx(1, 32'h22);
    grant_and_rx(2, 32'h33);
    grant_and_rx(3, 32'h44);
    @(negedge clk);
    check("t2_frame_count", fd_cnt_a - snap, 4);

    // 3: fairness - after grant to 1, req0+req1 together go 0 then 1
    bus_a.req_data[15:8] = 8'h5A;
    bus_a.req_valid[1]   = 1'b1;
    #1;
    grant_and_rx(1, 32'h5A);
    bus_a.req_data[7:0]  = 8'hC3;
    bus_a.req_data[15:8] = 8'h3C;
    bus_a.req_valid[0]   = 1'b1;
    bus_a.req_valid[1]   = 1'b1;
    #1;
    grant_and_rx(0, 32'hC3);
    grant_and_rx(1, 32'h3C);

    // 4: two stop bits, byte 0xFF on instance b
    @(negedge clk);
    bus_b.req_data[7:0] = 8'hFF;
    bus_b.req_valid[0]  = 1'b1;
    #1;
    check("t4_ready", 32'(bus_b.req_ready), 1);
    @(negedge clk);
    bus_b.req_valid[0] = 1'b0;
    check("t4_busy", 32'(busy_b), 1);
    rx_frame(1'b1, 2, b, bad, lows);
    check("t4_byte", 32'(b), 32'hFF);
    check("t4_timing", bad, 0);
    check("t4_low_clks", lows, 4);
    check("t4_frame_done", 32'(fd_b), 1);
    check("t4_busy_fall", 32'(busy_b), 0);

    // 5: reset during data bit 3 aborts the frame and rr_ptr
    bus_a.req_data[7:0] = 8'h0F;
    bus_a.req_valid[0]  = 1'b1;
    @(negedge clk);
    bus_a.req_valid[0] = 1'b0;
    for (int k = 0; k < 40 && tx_a !== 1'b0; k++) @(negedge clk);
    check("t5_start_seen", 32'(tx_a), 0);
    repeat (18) @(negedge clk);
    snap = fd_cnt_a;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_tx_high", 32'(tx_a), 1);
    check("t5_busy", 32'(busy_a), 0);
    check("t5_ready", 32'(bus_a.req_ready), 0);
    repeat (20) @(negedge clk);
    check("t5_no_frame_done", fd_cnt_a - snap, 0);
    check("t5_line_idle", 32'(tx_a), 1);
    bus_a.req_data[7:0]  = 8'h96;
    bus_a.req_data[15:8] = 8'h69;
    bus_a.req_valid[0]   = 1'b1;
    bus_a.req_valid[1]   = 1'b1;
    #1;
    grant_and_rx(0, 32'h96);
    grant_and_rx(1, 32'h69);

    // 6: req2 pulsed while busy is ignored
    @(negedge clk);
    snap = rdy2_cnt;
    bus_a.req_data[31:24] = 8'hE7;
    bus_a.req_valid[3]    = 1'b1;
    #1;
    check("t6_ready", 32'(bus_a.req_ready), 8);
    @(negedge clk);
    bus_a.req_valid[3] = 1'b0;
    bus_a.req_valid[2] = 1'b1;
    #1;
    check("t6_busy", 32'(busy_a), 1);
    check("t6_ready_zero_busy", 32'(bus_a.req_ready), 0);
    @(negedge clk);
    bus_a.req_valid[2] = 1'b0;
    begin
      int k;
      k = 0;
      while (k < 80 && fd_a !== 1'b1) begin
        @(negedge clk);
        k++;
      end
    end
    check("t6_frame_done", 32'(fd_a), 1);
    check("t6_grant_id", 32'(gid_a), 3);
    repeat (6) @(negedge clk);
    check("t6_no_grant2", rdy2_cnt - snap, 0);
    check("t6_idle", 32'(busy_a), 0);
    check("t6_grant_id_kept", 32'(gid_a), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
